// File: rtl/dp_control_unit.sv
// -----------------------------------------------------------------------------
// dp_control_unit
//
// Multi-cycle controller for the 16-bit register-file / ALU / data-memory
// datapath. It holds the program counter and instruction register, fetches
// from an instruction ROM with a combinational read, decodes the opcode and
// drives every datapath control input as a Moore function of the current
// state and the instruction register.
//
// Instruction word: op = IR[15:12]
//   0000 NOOP   0001 STORE D[IR[11:4]] <= R[IR[3:0]]
//   0010 LOAD   R[IR[3:0]] <= D[IR[11:4]]   (two execute cycles)
//   0011 ADD    R[IR[3:0]] <= R[IR[11:8]] + R[IR[7:4]]
//   0100 SUB    R[IR[3:0]] <= R[IR[11:8]] - R[IR[7:4]]
//   0101 HALT   stop until reset
//   0110-1111   undefined: executed as NOOP, illegal_op pulses in DECODE
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   reset_n     synchronous active-low reset
//   IM_addr     instruction ROM address (always the PC)
//   IM_data     instruction word read combinationally from IM_addr
//   D_Addr      data memory address
//   D_wr        data memory write enable
//   RF_s        write-back select: 0 = ALU result, 1 = data memory
//   RF_W_addr   register file write address
//   RF_W_en     register file write enable
//   RF_Ra_addr  register file read port A address
//   RF_Rb_addr  register file read port B address
//   Alu_s0      ALU operation select
//   halted      high while in HALT
//   state_dbg   current state encoding
//   illegal_op  one-cycle pulse in DECODE for an undefined opcode
// -----------------------------------------------------------------------------
module dp_control_unit #(
  parameter int          PC_W     = 7,
  parameter logic [3:0]  ALU_PASS = 4'd0,
  parameter logic [3:0]  ALU_ADD  = 4'd1,
  parameter logic [3:0]  ALU_SUB  = 4'd2
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [PC_W-1:0] IM_addr,
  input  logic [15:0]     IM_data,
  output logic [7:0]      D_Addr,
  output logic            D_wr,
  output logic            RF_s,
  output logic [3:0]      RF_W_addr,
  output logic            RF_W_en,
  output logic [3:0]      RF_Ra_addr,
  output logic [3:0]      RF_Rb_addr,
  output logic [3:0]      Alu_s0,
  output logic            halted,
  output logic [3:0]      state_dbg,
  output logic            illegal_op
);

  // State encodings are visible on state_dbg, so they are fixed explicitly.
  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  state_t            state_reg, state_next;
  logic [PC_W-1:0]   pc_reg, pc_next;
  logic [15:0]       ir_reg, ir_next;

  // Instruction fields
  logic [3:0] ir_op;
  logic [7:0] ir_daddr;
  logic [3:0] ir_ra;
  logic [3:0] ir_rb;
  logic [3:0] ir_rd;
  logic       op_defined;

  assign ir_op    = ir_reg[15:12];
  assign ir_daddr = ir_reg[11:4];
  assign ir_ra    = ir_reg[11:8];
  assign ir_rb    = ir_reg[7:4];
  assign ir_rd    = ir_reg[3:0];

  // Opcodes above HALT are undefined.
  assign op_defined = (ir_op <= OP_HALT);

  // ---------------------------------------------------------------------------
  // State, PC and IR registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= S_INIT;
      pc_reg    <= '0;
      ir_reg    <= 16'h0000;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. PC and IR only move in FETCH; the PC increment wraps
  // naturally at 2^PC_W.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;

    case (state_reg)
      S_INIT: begin
        state_next = S_FETCH;
      end

      S_FETCH: begin
        ir_next    = IM_data;
        pc_next    = pc_reg + PC_W'(1);
        state_next = S_DECODE;
      end

      S_DECODE: begin
        case (ir_op)
          OP_NOOP:  state_next = S_NOOP;
          OP_STORE: state_next = S_STORE;
          OP_LOAD:  state_next = S_LOAD_A;
          OP_ADD:   state_next = S_ADD;
          OP_SUB:   state_next = S_SUB;
          OP_HALT:  state_next = S_HALT;
          default:  state_next = S_NOOP;
        endcase
      end

      S_NOOP, S_STORE, S_ADD, S_SUB, S_LOAD_B: begin
        state_next = S_FETCH;
      end

      // First LOAD cycle presents the address to the synchronous data
      // memory; the write-back happens in LOAD_B once the data is valid.
      S_LOAD_A: begin
        state_next = S_LOAD_B;
      end

      S_HALT: begin
        state_next = S_HALT;
      end

      default: begin
        state_next = S_INIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore output decode from state and IR
  // ---------------------------------------------------------------------------
  always_comb begin
    D_Addr     = 8'h00;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = 4'h0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = 4'h0;
    RF_Rb_addr = 4'h0;
    Alu_s0     = ALU_PASS;
    halted     = 1'b0;
    illegal_op = 1'b0;

    case (state_reg)
      S_DECODE: begin
        illegal_op = ~op_defined;
      end

      S_STORE: begin
        D_Addr     = ir_daddr;
        RF_Ra_addr = ir_rd;
        D_wr       = 1'b1;
      end

      S_LOAD_A: begin
        D_Addr    = ir_daddr;
        RF_s      = 1'b1;
        RF_W_addr = ir_rd;
      end

      S_LOAD_B: begin
        D_Addr    = ir_daddr;
        RF_s      = 1'b1;
        RF_W_addr = ir_rd;
        RF_W_en   = 1'b1;
      end

      S_ADD: begin
        RF_Ra_addr = ir_ra;
        RF_Rb_addr = ir_rb;
        RF_W_addr  = ir_rd;
        Alu_s0     = ALU_ADD;
        RF_W_en    = 1'b1;
      end

      S_SUB: begin
        RF_Ra_addr = ir_ra;
        RF_Rb_addr = ir_rb;
        RF_W_addr  = ir_rd;
        Alu_s0     = ALU_SUB;
        RF_W_en    = 1'b1;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
      end
    endcase
  end

  assign IM_addr   = pc_reg;
  assign state_dbg = state_reg;

endmodule

// File: doc/dp_control_unit.md
Name: dp_control_unit

Overview:
- Multi-cycle FSM controller that sequences the 16-bit register-file/ALU/data-memory datapath.
- Holds the program counter (PC) and instruction register (IR), and fetches instructions from an instruction ROM.
- Decodes each instruction and drives every datapath control input: D_Addr, D_wr, RF_s, RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, Alu_s0.
- Sits between the instruction ROM and the datapath at CPU top level.

Parameters:
- PC_W, 7, PC / instruction-ROM address width.
- ALU_PASS, 4'd0, ALU select value for idle/pass-through.
- ALU_ADD, 4'd1, ALU select value for A+B.
- ALU_SUB, 4'd2, ALU select value for A-B.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- IM_addr  out  PC_W  instruction ROM address; equals PC.
- IM_data  in  16  instruction word; combinational read of IM_addr.
- D_Addr  out  8  data memory address.
- D_wr  out  1  data memory write enable.
- RF_s  out  1  write-back mux select: 0 = ALU, 1 = data memory.
- RF_W_addr  out  4  register file write address.
- RF_W_en  out  1  register file write enable.
- RF_Ra_addr  out  4  register file read port A address.
- RF_Rb_addr  out  4  register file read port B address.
- Alu_s0  out  4  ALU operation select.
- halted  out  1  high while in HALT.
- state_dbg  out  4  current state encoding, for debug.
- illegal_op  out  1  one-cycle pulse in DECODE when the opcode is undefined.

Behaviour:
- One clock domain. Reset is synchronous, active-low: sampled on the rising clk edge while reset_n=0.
- Reset actions: PC=0, IR=16'h0000, state=INIT. Reset applies from any state, including mid-LOAD and HALT.
- Reset output values: every control output is 0, Alu_s0=ALU_PASS, halted=0, illegal_op=0, state_dbg=INIT.
- Instruction format: op=IR[15:12].
  - NOOP 0000: no operation.
  - STORE 0001: D[IR[11:4]] <= R[IR[3:0]].
  - LOAD 0010: R[IR[3:0]] <= D[IR[11:4]].
  - ADD 0011: R[IR[3:0]] <= R[IR[11:8]] + R[IR[7:4]].
  - SUB 0100: R[IR[3:0]] <= R[IR[11:8]] - R[IR[7:4]].
  - HALT 0101: stop execution.
  - Opcodes 0110-1111 are undefined: treated as NOOP, with illegal_op pulsed.
- State encodings: INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9.
- Transitions:
  - INIT -> FETCH.
  - FETCH: IR<=IM_data, PC<=PC+1, -> DECODE.
  - DECODE -> the execute state selected by op; undefined op -> NOOP.
  - NOOP, STORE, ADD, SUB, LOAD_B -> FETCH.
  - LOAD_A -> LOAD_B.
  - HALT -> HALT; only reset exits.
- Outputs are Moore, decoded combinationally from state and IR. Default every output to 0 and Alu_s0 to ALU_PASS; the states below override only the listed signals.
  - STORE: D_Addr=IR[11:4], RF_Ra_addr=IR[3:0], D_wr=1.
  - LOAD_A: D_Addr=IR[11:4], RF_s=1, RF_W_addr=IR[3:0], RF_W_en=0.
  - LOAD_B: same as LOAD_A but RF_W_en=1. The extra cycle covers the synchronous data-memory read.
  - ADD: RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], RF_W_addr=IR[3:0], Alu_s0=ALU_ADD, RF_s=0, RF_W_en=1.
  - SUB: same as ADD but Alu_s0=ALU_SUB.
  - HALT: halted=1.
- Latency per instruction, FETCH to next FETCH:
  - NOOP, STORE, ADD, SUB and undefined opcodes: 3 cycles.
  - LOAD: 4 cycles.
- At most one of D_wr and RF_W_en is high in any cycle.
- PC wraps from 2^PC_W-1 to 0 with no flag. PC changes only in FETCH.
- IR changes only in FETCH (or reset); IM_data is ignored in every other state.
- An IR destination field of R0 is legal and gets no special handling.

Test Plan:
- Hold reset_n=0 for 2 cycles, then release -> all outputs 0 during reset; state_dbg=0,1,2 on the next three cycles; IM_addr=0 in the first FETCH, then 1.
- ROM[0]=16'h2053 (LOAD R3<=D[0x05]) -> LOAD_A: D_Addr=8'h05, RF_s=1, RF_W_addr=3, RF_W_en=0; LOAD_B: same with RF_W_en=1; next FETCH 4 cycles after the first.
- ROM[1]=16'h3124 (ADD R4<=R1+R2), ROM[2]=16'h4124 (SUB) -> execute cycle shows Ra=1, Rb=2, W_addr=4, W_en=1, RF_s=0, with Alu_s0=1 for ADD and 2 for SUB.
- ROM[3]=16'h10A7 (STORE D[0x0A]<=R7) -> D_wr=1, D_Addr=8'h0A, RF_Ra_addr=7, RF_W_en=0 for exactly one cycle.
- ROM[4]=16'hF000, ROM[5]=16'h5000 -> illegal_op pulses once and a NOOP path is taken; then HALT: halted=1, PC stays at 6 for 20+ cycles; driving reset_n=0 for one cycle returns to INIT with PC=0.
- PC preloaded to 127 by executing 127 NOOPs -> after fetching from 127, IM_addr=0. Assert reset_n=0 during LOAD_A -> the next cycle shows INIT with RF_W_en=0, so no register write occurs.
